// File: rtl/img_ddr_pkg.sv
// Shared constants and FSM encoding for the image DDR responder.
package img_ddr_pkg;

    localparam int unsigned DEF_ADDR_W    = 19;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_MEM_WORDS = 307200;
    localparam int unsigned CNT_W         = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WR,
        WAIT_RD,
        RESP,
        HOLD
    } state_t;

endpackage

// File: rtl/img_ddr_mem.sv
// Registered-read byte array; IMG_DDR_UART_PORT_EN adds a second read/write port.
module img_ddr_mem
    import img_ddr_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MEM_WORDS = DEF_MEM_WORDS
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic [DATA_W-1:0] q_a
`ifdef IMG_DDR_UART_PORT_EN
    ,
    input  logic              rst_n,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic [DATA_W-1:0] q_b
`endif
);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    // Port A is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
`ifdef IMG_DDR_UART_PORT_EN
        if (we_b && (32'(addr_b) < MEM_WORDS)) begin
            mem[addr_b] <= wdata_b;
        end
`endif
        if (we_a) begin
            mem[addr_a] <= wdata_a;
        end
        q_a <= mem[addr_a];
    end

`ifdef IMG_DDR_UART_PORT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_b <= '0;
        end else begin
            q_b <= mem[addr_b];
        end
    end
`endif

endmodule

// File: rtl/img_ddr_responder.sv
// Cache miss/writeback responder with programmable latency over an on-chip byte array.
// Optional UART side port enabled by defining IMG_DDR_UART_PORT_EN.
module img_ddr_responder
    import img_ddr_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MEM_WORDS = DEF_MEM_WORDS,
    parameter int unsigned RD_LAT    = 4,
    parameter int unsigned WR_LAT    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_we,
    input  logic              req_re,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              wr_ready,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
`ifdef IMG_DDR_UART_PORT_EN
    ,
    input  logic              uart_we,
    input  logic [ADDR_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_data,
    output logic [DATA_W-1:0] uart_q
`endif
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] mem_q;
    logic              addr_ok_c;
    logic              last_wait_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;

    assign addr_ok_c   = (32'(addr_q) < MEM_WORDS);
    assign last_wait_c = (cnt == CNT_W'(1));
    // Commit happens on the edge entering RESP; reset suppresses it.
    assign mem_we_c    = rst_n && (state == WAIT_WR) && last_wait_c && addr_ok_c;
    // In IDLE the array is addressed straight from the request so a 1-cycle read latency works.
    assign mem_addr_c  = (state == IDLE) ? req_addr : addr_q;

    img_ddr_mem #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_WORDS(MEM_WORDS)
    ) u_mem (
        .clk    (clk),
        .we_a   (mem_we_c),
        .addr_a (mem_addr_c),
        .wdata_a(data_q),
        .q_a    (mem_q)
`ifdef IMG_DDR_UART_PORT_EN
        ,
        .rst_n  (rst_n),
        .we_b   (uart_we),
        .addr_b (uart_addr),
        .wdata_b(uart_data),
        .q_b    (uart_q)
`endif
    );

    // Request FSM: accept, count down latency, pulse ready, one dead cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wr_ready <= 1'b0;
            rd_ready <= 1'b0;
            rd_data  <= '0;
            busy     <= 1'b0;
        end else begin
            wr_ready <= 1'b0;
            rd_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_we || req_re) begin
                        addr_q <= req_addr;
                        data_q <= req_data;
                        busy   <= 1'b1;
                        if (req_we) begin
                            cnt   <= CNT_W'(WR_LAT);
                            state <= WAIT_WR;
                        end else begin
                            cnt   <= CNT_W'(RD_LAT);
                            state <= WAIT_RD;
                        end
                    end
                end
                WAIT_WR, WAIT_RD: begin
                    if (last_wait_c) begin
                        cnt   <= '0;
                        state <= RESP;
                        if (state == WAIT_RD) begin
                            rd_ready <= 1'b1;
                            rd_data  <= addr_ok_c ? mem_q : '0;
                        end else begin
                            wr_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= HOLD;
                end
                HOLD: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
